// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, handshake levels, bus widths.
// Latency: n/a (constants only).
// Backpressure: n/a; consumers are div_unit and anything decoding its stall request.
package div_unit_pkg;

  // Divider FSM state encodings
  localparam logic [1:0] DivFree   = 2'b00;  // idle, waiting for a request
  localparam logic [1:0] DivByZero = 2'b01;  // divisor was zero, result forced to 0
  localparam logic [1:0] DivOn     = 2'b10;  // restoring steps in progress
  localparam logic [1:0] DivEnd    = 2'b11;  // result presented for one cycle

  // Request / stall / reset levels
  localparam logic DivStart     = 1'b1;
  localparam logic DivStop      = 1'b0;
  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;

  // Width of the {remainder, quotient} bus for the default 32-bit datapath
  localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the EX stage, result goes to HI/LO.
// Latency: accept at T0, result + ready_o at T33 (T2 for divide-by-zero); back-to-back with no gap.
// Backpressure: none accepted; the unit itself stalls PC/IF/ID/EX via stallreq_o while busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start_i, signed_i   request (held high by EX while stalled), signed/unsigned select
//   annul_i             abort current operation, back to idle next cycle
//   opdata1_i/2_i       dividend / divisor, sampled at accept
//   result_o            {remainder, quotient}, registered, valid only while ready_o=1
//   ready_o             one-cycle result strobe
//   stallreq_o          combinational stall request
//   divzero_o           only when DIV_ZERO_FLAG_EN is defined: high with ready_o for a zero divisor
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               divzero_o
`endif
);

  localparam logic [5:0] CntLast = 6'(WIDTH - 1);

  logic [1:0]       state;
  logic [5:0]       cnt;
  logic [2*WIDTH:0] pr;       // {partial remainder, dividend/quotient shift register}
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic             neg_q;    // negate quotient at the end
  logic             neg_r;    // negate remainder at the end

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             ge;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] pr_next;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_abs = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_abs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Trial subtract on the shifted remainder plus the next dividend bit. The
    // comparison uses the full W+2-bit window; the difference only needs W+1
    // bits because it is kept only when it is smaller than the divisor.
    ge      = pr[2*WIDTH:WIDTH-1] >= {2'b00, dvs};
    diff    = pr[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
    pr_next = ge ? {diff, pr[WIDTH-2:0], 1'b1}
                 : {pr[2*WIDTH-1:0], 1'b0};

    q_mag = pr_next[WIDTH-1:0];
    r_mag = pr_next[2*WIDTH-1:WIDTH];
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, no negation.
    q_fix = neg_q ? -q_mag : q_mag;
    r_fix = neg_r ? -r_mag : r_mag;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic divzero_q;
  assign divzero_o = divzero_q;
`endif

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      pr       <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
      divzero_q <= 1'b0;
`endif
    end else if (annul_i) begin
      state <= DivFree;
`ifdef DIV_ZERO_FLAG_EN
      divzero_q <= 1'b0;
`endif
    end else begin
`ifdef DIV_ZERO_FLAG_EN
      divzero_q <= 1'b0;
`endif
      case (state)
        DivFree: begin
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              pr    <= {{(WIDTH+1){1'b0}}, a_abs};
              dvs   <= b_abs;
              neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r <= signed_i && opdata1_i[WIDTH-1];
              cnt   <= '0;
              state <= DivOn;
            end
          end
        end
        DivByZero: begin
          result_o <= '0;
          state    <= DivEnd;
`ifdef DIV_ZERO_FLAG_EN
          divzero_q <= 1'b1;
`endif
        end
        DivOn: begin
          pr  <= pr_next;
          cnt <= cnt + 6'd1;
          // Final step: register the sign-corrected result so it is present in DivEnd.
          if (cnt == CntLast) begin
            result_o <= {r_fix, q_fix};
            state    <= DivEnd;
          end
        end
        default: begin
          state <= DivFree;
        end
      endcase
    end
  end

  assign ready_o = (state == DivEnd);

  // Low in DivEnd so the result can advance to EX/MEM.
  assign stallreq_o = (!rst && !annul_i &&
                       ((state == DivFree && start_i == DivStart) ||
                        state == DivOn || state == DivByZero)) ? StallEnable : StallDisable;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized divisions vs a reference model.
// Latency: checks 33-cycle normal and 2-cycle divide-by-zero completion, back-to-back with no gap.
// Backpressure: drives start_i held high through the stall, checks stallreq_o each cycle.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        divzero_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .divzero_o (divzero_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue a division at the next cycle (T0), hold start_i until ready_o, check
  // latency, result, and that stallreq_o was high every cycle before ready_o and low with it.
  // Returns in the ready_o cycle, so a following call issues at T(latency+1).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    int          t;
    logic        stall_ok;
    logic [63:0] exp;
    exp = ref_div(a, b, sgn);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    t        = 0;
    stall_ok = 1'b1;
    while (!ready_o && t < 100) begin
      if (!stallreq_o) stall_ok = 1'b0;
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, " latency"}, 64'(t), (b == 32'd0) ? 64'd2 : 64'd33);
    check({tag, " result"}, result_o, exp);
    check({tag, " stall"}, 64'({stall_ok, stallreq_o}), 64'(2'b10));
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " divzero"}, 64'(divzero_o), 64'(b == 32'd0));
`endif
  endtask

  // Drop start_i; ready_o must have been a single-cycle pulse.
  task automatic idle(input int n);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("ready pulse", 64'(ready_o), 64'd0);
    check("idle stall", 64'(stallreq_o), 64'd0);
    repeat (n) @(negedge clk);
  endtask

  // Watch n cycles; no ready_o may appear.
  task automatic no_ready(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (ready_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          mode;

    // Reset with start_i high: stall request must stay low while in reset.
    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd5; opdata2_i = 32'd1;
    repeat (2) @(negedge clk);
    #1;
    check("rst ready", 64'(ready_o), 64'd0);
    check("rst stall", 64'(stallreq_o), 64'd0);
    check("rst result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    #1;
    check("post-rst result", result_o, 64'd0);
    idle(1);

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, "u100/7");
    check("u100/7 exact", result_o, {32'd2, 32'd14});
    idle(1);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, "s-7/2");
    check("s-7/2 exact", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    idle(0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b0, "u-7/2");
    check("u-7/2 exact", result_o, {32'd1, 32'h7FFFFFFC});
    idle(0);
    do_div(32'h1234, 32'd0, 1'b0, "div0");
    check("div0 exact", result_o, 64'd0);
    idle(2);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "s-min/-1");
    check("s-min/-1 exact", result_o, {32'd0, 32'h80000000});
    idle(1);

    // Annul at T10: stall drops immediately, unit is idle next cycle, no result.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    check("annul idle stall", 64'(stallreq_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    no_ready(40, "annul no ready");
    do_div(32'd9, 32'd3, 1'b0, "after annul 9/3");
    check("9/3 exact", result_o, {32'd0, 32'd3});
    idle(1);

    // Synchronous reset at T5 discards the operation.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("midrst stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    check("midrst idle stall", 64'(stallreq_o), 64'd0);
    no_ready(40, "midrst no ready");

    // Back-to-back: second accept in the cycle right after DONE.
    do_div(32'd20, 32'd6, 1'b0, "b2b 20/6");
    check("20/6 exact", result_o, {32'd2, 32'd3});
    do_div(32'd21, 32'd6, 1'b0, "b2b 21/6");
    check("21/6 exact", result_o, {32'd3, 32'd3});
    idle(1);

    // Randomized divisions against the reference model.
    for (int i = 0; i < 24; i++) begin
      a    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        default: b = $urandom;
      endcase
      if (mode == 4) a = 32'h80000000;
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, $sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        // chain straight into the next one without dropping start_i
      end else begin
        idle($urandom_range(0, 2));
      end
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
